fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be forced to 0.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_00FC, PC value loaded on exception; bits [1:0] SHALL be forced to 0.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_req  output  1  instruction memory read request.
REQ-006 mem_addr  output  32  instruction address; always equals pc.
REQ-007 mem_ready  input  1  memory returns mem_rdata this cycle.
REQ-008 mem_rdata  input  32  fetched instruction word.
REQ-009 instr_ack  input  1  decode consumes the presented instruction.
REQ-010 stall  input  1  hazard hold from downstream.
REQ-011 pc_src  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 reserved (treated as 00).
REQ-012 branch_taken  input  1  branch condition, qualifies pc_src=01.
REQ-013 exception  input  1  redirect to EXC_VECTOR, highest priority.
REQ-014 pc  output  32  address of current instruction.
REQ-015 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-016 instr  output  32  instruction register (IR).
REQ-017 instr_valid  output  1  IR holds a valid instruction for decode.
REQ-018 rs / rt / imm  output  5 / 5 / 16  IR[25:21], IR[20:16], IR[15:0].
REQ-019 jump_target  output  32  {pc_plus4[31:28], IR[25:0], 2'b00}.

Function
REQ-020 FSM states: FLUSH, FETCH, ISSUE.
REQ-021 FLUSH: mem_req=0, instr_valid=0, mem_ready ignored; next state FETCH after exactly one cycle.
REQ-022 FETCH: mem_req=1, instr_valid=0; on mem_ready, IR<=mem_rdata and next state ISSUE; otherwise remain in FETCH.
REQ-023 ISSUE: mem_req=0, instr_valid=1; when instr_ack=1 and stall=0, pc<=next_pc and next state FETCH; otherwise pc, IR and state hold.
REQ-024 next_pc, in priority order: pc_src=10 -> jump_target; pc_src=01 and branch_taken=1 -> pc_plus4 + (sign-extended imm << 2); otherwise pc_plus4.
REQ-025 Branch arithmetic SHALL be 32-bit and wrap modulo 2^32; carry is discarded.
REQ-026 exception=1 in any state: pc<=EXC_VECTOR, IR unchanged, next state FLUSH; this overrides instr_ack, mem_ready and stall in the same cycle.
REQ-027 In FETCH, stall has no effect; a fetch completes regardless of stall.
REQ-028 Minimum latency: 1 cycle from FETCH entry with mem_ready=1 to instr_valid=1; ack-to-next-request is 1 cycle.
REQ-029 pc[1:0] SHALL always read 00.
REQ-030 rs, rt, imm and jump_target SHALL be combinational from IR and pc_plus4; they are valid only while instr_valid=1.

Reset
REQ-031 While reset=1: state=FLUSH, pc=RESET_PC, IR=0, mem_req=0, instr_valid=0; takes effect without a clock edge.
REQ-032 If reset is asserted mid-fetch, any later mem_ready for the aborted request SHALL be discarded via FLUSH.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the pc_src encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JMP) and the fetch-state enum.
REQ-034 One sub-module SHALL be used: sign_ext_16_32, which sign-extends imm for the branch adder.

Verification
REQ-035 Reset release, mem_ready=1 every cycle, ack=1 -> mem_addr sequence 0x0,0x4,0x8; instr matches mem_rdata.
REQ-036 IR=0x0800_0010 at pc=0x1000_0000, pc_src=10, ack -> next mem_addr=0x1000_0040.
REQ-037 IR imm=0xFFFF at pc=0x100, pc_src=01, branch_taken=1 -> next pc=0x100; with branch_taken=0 -> 0x104.
REQ-038 In ISSUE with stall=1 and ack=1 for 3 cycles -> pc, instr and instr_valid=1 all unchanged; release stall -> advance.
REQ-039 exception=1 in FETCH with mem_ready=1 in the same cycle -> pc=0xFC, IR unchanged, one FLUSH cycle with mem_req=0, then fetch at 0xFC.
REQ-040 pc=0xFFFF_FFFC sequential -> next pc=0x0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: next-PC select encodings, fetch FSM states
// and the word-alignment helper used for every PC load.
package cpu_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/sign_ext_16_32.sv
// Sign-extends a 16-bit immediate to 32 bits for the branch adder.
module sign_ext_16_32 (
  input  logic signed [15:0] i_imm,
  output logic signed [31:0] o_ext
);
  assign o_ext = 32'(i_imm);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FLUSH/FETCH/ISSUE sequencer holding PC and the
// instruction register, with jump/branch/exception next-PC selection.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       mem,
  input  logic               instr_ack,
  input  logic               stall,
  input  logic [1:0]         pc_src,
  input  logic               branch_taken,
  input  logic               exception,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [15:0]        imm,
  output logic [31:0]        jump_target
);

  fetch_state_e       r_state;
  fetch_state_e       w_next_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_ir;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_jump_target;
  logic [31:0]        w_br_target;
  logic [31:0]        w_next_pc;
  logic [31:0]        w_pc_d;
  logic               w_pc_load;
  logic               w_ir_load;
  logic               w_mem_req;
  logic               w_instr_valid;
  logic signed [31:0] w_imm_sext;
  logic signed [31:0] w_br_off;

  sign_ext_16_32 u_sext (
    .i_imm (r_ir[15:0]),
    .o_ext (w_imm_sext)
  );

  // Target arithmetic is plain 32-bit; carries out of bit 31 are dropped.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_br_off      = w_imm_sext <<< 2;
  assign w_br_target   = w_pc_plus4 + $unsigned(w_br_off);
  assign w_jump_target = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (pc_src == PCSRC_JMP)
      w_next_pc = w_jump_target;
    else if (pc_src == PCSRC_BR && branch_taken)
      w_next_pc = w_br_target;
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc_load     = 1'b0;
    w_pc_d        = w_next_pc;
    w_ir_load     = 1'b0;
    w_mem_req     = 1'b0;
    w_instr_valid = 1'b0;
    case (r_state)
      ST_FLUSH: w_next_state = ST_FETCH;
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (mem.mem_ready) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_instr_valid = 1'b1;
        if (instr_ack && !stall) begin
          w_pc_load    = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      default: w_next_state = ST_FLUSH;
    endcase
    // Exception wins over every handshake; FLUSH drops any in-flight response.
    if (exception) begin
      w_next_state = ST_FLUSH;
      w_pc_load    = 1'b1;
      w_pc_d       = word_align(EXC_VECTOR);
      w_ir_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FLUSH;
      r_pc    <= word_align(RESET_PC);
      r_ir    <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_pc_load)
        r_pc <= word_align(w_pc_d);
      if (w_ir_load)
        r_ir <= mem.mem_rdata;
    end
  end

  assign mem.mem_req  = w_mem_req;
  assign mem.mem_addr = r_pc;
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign instr        = r_ir;
  assign instr_valid  = w_instr_valid;
  assign rs           = r_ir[25:21];
  assign rt           = r_ir[20:16];
  assign imm          = r_ir[15:0];
  assign jump_target  = w_jump_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table on a default-parameter
// instance plus hand sequences on a second instance for high-address cases.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 1: default parameters
  logic        reset;
  logic        ack, stall, bt, exc;
  logic [1:0]  src;
  logic [31:0] pc, pc_plus4, instr, jt;
  logic        vld;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  fetch_unit_if mif ();

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .mem(mif),
    .instr_ack(ack), .stall(stall), .pc_src(src), .branch_taken(bt), .exception(exc),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(vld),
    .rs(rs), .rt(rt), .imm(imm), .jump_target(jt)
  );

  // Instance 2: high reset PC, misaligned exception vector
  logic        reset2;
  logic        ack2, stall2, bt2, exc2;
  logic [1:0]  src2;
  logic [31:0] pc2, pc_plus4_2, instr2, jt2;
  logic        vld2;
  logic [4:0]  rs2, rt2;
  logic [15:0] imm2;
  fetch_unit_if mif2 ();

  fetch_unit #(.RESET_PC(32'h1000_0000), .EXC_VECTOR(32'hFFFF_FFFE)) u_dut2 (
    .clk(clk), .reset(reset2), .mem(mif2),
    .instr_ack(ack2), .stall(stall2), .pc_src(src2), .branch_taken(bt2), .exception(exc2),
    .pc(pc2), .pc_plus4(pc_plus4_2), .instr(instr2), .instr_valid(vld2),
    .rs(rs2), .rt(rt2), .imm(imm2), .jump_target(jt2)
  );

  typedef struct {
    logic        req;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        rdy;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic [1:0]  src;
    logic        bt;
    logic        exc;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic e_req, input logic e_vld, input logic [31:0] e_pc,
                              input logic [31:0] e_ir, input logic i_rdy, input logic [31:0] i_rdata,
                              input logic i_ack, input logic i_stall, input logic [1:0] i_src,
                              input logic i_bt, input logic i_exc);
    vec_t v;
    v.req = e_req; v.vld = e_vld; v.pc = e_pc; v.ir = e_ir;
    v.rdy = i_rdy; v.rdata = i_rdata; v.ack = i_ack; v.stall = i_stall;
    v.src = i_src; v.bt = i_bt; v.exc = i_exc;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", nm, row, act, exp);
    end
  endtask

  initial begin
    logic [31:0] epc4;
    reset = 1'b0; reset2 = 1'b0;
    ack = 0; stall = 0; bt = 0; exc = 0; src = 2'b00;
    mif.mem_ready = 0; mif.mem_rdata = 32'd0;
    ack2 = 0; stall2 = 0; bt2 = 0; exc2 = 0; src2 = 2'b00;
    mif2.mem_ready = 0; mif2.mem_rdata = 32'd0;

    //          req vld pc            ir            rdy rdata         ack st src   bt exc
    vecs[0]  = mk(0, 0, 32'h0,        32'h0,        1, 32'hDEAD_BEEF, 0, 0, 2'd0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h0,        32'h0,        1, 32'h1111_0000, 1, 0, 2'd0, 0, 0);
    vecs[2]  = mk(0, 1, 32'h0,        32'h1111_0000,1, 32'h0,         1, 0, 2'd0, 0, 0);
    vecs[3]  = mk(1, 0, 32'h4,        32'h1111_0000,0, 32'h0,         0, 0, 2'd0, 0, 0);
    vecs[4]  = mk(1, 0, 32'h4,        32'h1111_0000,1, 32'h2222_0004, 0, 0, 2'd0, 0, 0);
    vecs[5]  = mk(0, 1, 32'h4,        32'h2222_0004,0, 32'h0,         0, 0, 2'd0, 0, 0);
    vecs[6]  = mk(0, 1, 32'h4,        32'h2222_0004,0, 32'h0,         1, 1, 2'd0, 0, 0);
    vecs[7]  = mk(0, 1, 32'h4,        32'h2222_0004,0, 32'h0,         1, 1, 2'd0, 0, 0);
    vecs[8]  = mk(0, 1, 32'h4,        32'h2222_0004,0, 32'h0,         1, 1, 2'd0, 0, 0);
    vecs[9]  = mk(0, 1, 32'h4,        32'h2222_0004,0, 32'h0,         1, 0, 2'd0, 0, 0);
    vecs[10] = mk(1, 0, 32'h8,        32'h2222_0004,1, 32'h3333_0008, 0, 1, 2'd0, 0, 0);
    vecs[11] = mk(0, 1, 32'h8,        32'h3333_0008,0, 32'h0,         1, 0, 2'd3, 0, 0);
    vecs[12] = mk(1, 0, 32'hC,        32'h3333_0008,1, 32'h1000_0003, 0, 0, 2'd0, 0, 0);
    vecs[13] = mk(0, 1, 32'hC,        32'h1000_0003,0, 32'h0,         1, 0, 2'd1, 1, 0);
    vecs[14] = mk(1, 0, 32'h1C,       32'h1000_0003,1, 32'h0800_0010, 0, 0, 2'd0, 0, 0);
    vecs[15] = mk(0, 1, 32'h1C,       32'h0800_0010,0, 32'h0,         1, 0, 2'd2, 1, 0);
    vecs[16] = mk(1, 0, 32'h40,       32'h0800_0010,1, 32'hAAAA_AAAA, 0, 0, 2'd0, 0, 1);
    vecs[17] = mk(0, 0, 32'hFC,       32'h0800_0010,1, 32'h5555_5555, 0, 0, 2'd0, 0, 0);
    vecs[18] = mk(1, 0, 32'hFC,       32'h0800_0010,1, 32'h1234_5678, 0, 0, 2'd0, 0, 0);
    vecs[19] = mk(0, 1, 32'hFC,       32'h1234_5678,1, 32'h0,         1, 0, 2'd0, 0, 1);
    vecs[20] = mk(0, 0, 32'hFC,       32'h1234_5678,0, 32'h0,         0, 0, 2'd0, 0, 0);
    vecs[21] = mk(1, 0, 32'hFC,       32'h1234_5678,1, 32'h0,         0, 0, 2'd0, 0, 0);
    vecs[22] = mk(0, 1, 32'hFC,       32'h0,        0, 32'h0,         1, 0, 2'd0, 0, 0);
    vecs[23] = mk(1, 0, 32'h100,      32'h0,        1, 32'h0000_FFFF, 0, 0, 2'd0, 0, 0);
    vecs[24] = mk(0, 1, 32'h100,      32'h0000_FFFF,0, 32'h0,         1, 0, 2'd1, 1, 0);
    vecs[25] = mk(1, 0, 32'h100,      32'h0000_FFFF,1, 32'h0000_FFFF, 0, 0, 2'd0, 0, 0);
    vecs[26] = mk(0, 1, 32'h100,      32'h0000_FFFF,0, 32'h0,         1, 0, 2'd1, 0, 0);
    vecs[27] = mk(1, 0, 32'h104,      32'h0000_FFFF,1, 32'h0BE5_8004, 0, 0, 2'd0, 0, 0);
    vecs[28] = mk(0, 1, 32'h104,      32'h0BE5_8004,0, 32'h0,         1, 0, 2'd2, 1, 0);
    vecs[29] = mk(1, 0, 32'h0F96_0010,32'h0BE5_8004,0, 32'h0,         0, 0, 2'd0, 0, 0);
    vecs[30] = mk(1, 0, 32'h0F96_0010,32'h0BE5_8004,1, 32'h0,         0, 0, 2'd0, 0, 0);
    vecs[31] = mk(0, 1, 32'h0F96_0010,32'h0,        0, 32'h0,         0, 0, 2'd0, 0, 0);

    // Asynchronous reset: outputs must change before any clock edge
    #1 reset = 1'b1; reset2 = 1'b1;
    #1;
    chk("rst_req", 0, 32'(mif.mem_req), 32'd0);
    chk("rst_vld", 0, 32'(vld), 32'd0);
    chk("rst_pc",  0, pc, 32'h0);
    chk("rst_ir",  0, instr, 32'h0);
    chk("rst2_pc", 0, pc2, 32'h1000_0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      chk("mem_req",  i, 32'(mif.mem_req), 32'(vecs[i].req));
      chk("instr_vld",i, 32'(vld), 32'(vecs[i].vld));
      chk("mem_addr", i, mif.mem_addr, vecs[i].pc);
      chk("pc",       i, pc, vecs[i].pc);
      chk("instr",    i, instr, vecs[i].ir);
      if (vecs[i].vld) begin
        epc4 = vecs[i].pc + 32'd4;
        chk("pc_plus4", i, pc_plus4, epc4);
        chk("rs",       i, 32'(rs),  32'(vecs[i].ir[25:21]));
        chk("rt",       i, 32'(rt),  32'(vecs[i].ir[20:16]));
        chk("imm",      i, 32'(imm), 32'(vecs[i].ir[15:0]));
        chk("jump_tgt", i, jt, {epc4[31:28], vecs[i].ir[25:0], 2'b00});
      end
      mif.mem_ready = vecs[i].rdy; mif.mem_rdata = vecs[i].rdata;
      ack = vecs[i].ack; stall = vecs[i].stall; src = vecs[i].src;
      bt = vecs[i].bt; exc = vecs[i].exc;
    end

    // Instance 2: jump from 0x1000_0000, exception vector alignment, PC wrap
    reset2 = 1'b0;
    chk("d2_flush_req", 100, 32'(mif2.mem_req), 32'd0);
    chk("d2_flush_pc",  100, pc2, 32'h1000_0000);
    mif2.mem_ready = 1'b1; mif2.mem_rdata = 32'h0800_0010;
    @(negedge clk);
    chk("d2_fetch_req",  101, 32'(mif2.mem_req), 32'd1);
    chk("d2_fetch_addr", 101, mif2.mem_addr, 32'h1000_0000);
    @(negedge clk);
    chk("d2_issue_vld",  102, 32'(vld2), 32'd1);
    chk("d2_issue_ir",   102, instr2, 32'h0800_0010);
    chk("d2_jump_tgt",   102, jt2, 32'h1000_0040);
    chk("d2_rs_rt",      102, {22'd0, rs2, rt2}, 32'd0);
    chk("d2_imm",        102, 32'(imm2), 32'h10);
    ack2 = 1'b1; src2 = PCSRC_JMP; mif2.mem_ready = 1'b0;
    @(negedge clk);
    chk("d2_jump_addr",  103, mif2.mem_addr, 32'h1000_0040);
    chk("d2_jump_req",   103, 32'(mif2.mem_req), 32'd1);
    ack2 = 1'b0; src2 = PCSRC_SEQ; exc2 = 1'b1;
    mif2.mem_ready = 1'b1; mif2.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("d2_exc_pc",     104, pc2, 32'hFFFF_FFFC);
    chk("d2_exc_req",    104, 32'(mif2.mem_req), 32'd0);
    chk("d2_exc_ir",     104, instr2, 32'h0800_0010);
    exc2 = 1'b0; mif2.mem_rdata = 32'h0;
    @(negedge clk);
    chk("d2_exc_fetch",  105, mif2.mem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("d2_wrap_p4",    106, pc_plus4_2, 32'h0);
    chk("d2_wrap_ir",    106, instr2, 32'h0);
    ack2 = 1'b1; mif2.mem_ready = 1'b0;
    @(negedge clk);
    chk("d2_wrap_addr",  107, mif2.mem_addr, 32'h0);
    ack2 = 1'b0;

    // Reset mid-fetch; a late response must be dropped by the FLUSH cycle
    #2 reset2 = 1'b1;
    #1;
    chk("d2_mid_req",    108, 32'(mif2.mem_req), 32'd0);
    chk("d2_mid_pc",     108, pc2, 32'h1000_0000);
    chk("d2_mid_ir",     108, instr2, 32'h0);
    chk("d2_mid_vld",    108, 32'(vld2), 32'd0);
    mif2.mem_ready = 1'b1; mif2.mem_rdata = 32'hBADB_AD00;
    @(negedge clk);
    reset2 = 1'b0;
    chk("d2_post_req",   109, 32'(mif2.mem_req), 32'd0);
    @(negedge clk);
    chk("d2_stale_ir",   110, instr2, 32'h0);
    chk("d2_stale_req",  110, 32'(mif2.mem_req), 32'd1);
    chk("d2_stale_vld",  110, 32'(vld2), 32'd0);
    mif2.mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
